// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the MIPS datapath.
// The master side is the controller; the slave side is the datapath/memory.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  // Datapath to controller
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             Zero;
  logic             dm_ack;
  // Controller to datapath
  logic             IRWr;
  logic             PCWr;
  logic [1:0]       NPCOp;
  logic [2:0]       ALUOp;
  logic [1:0]       A3WRSel;
  logic [1:0]       WDSel;
  logic             EXTOp;
  logic             ALUBSel;
  logic             RFWE;
  logic             dm_req;
  logic             DMWr;
  // Status / debug
  logic [2:0]       state;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, funct, Zero, dm_ack,
    output IRWr, PCWr, NPCOp, ALUOp, A3WRSel, WDSel, EXTOp, ALUBSel, RFWE,
    output dm_req, DMWr, state, illegal, mem_err, retired
  );

  modport slave (
    output opcode, funct, Zero, dm_ack,
    input  IRWr, PCWr, NPCOp, ALUOp, A3WRSel, WDSel, EXTOp, ALUBSel, RFWE,
    input  dm_req, DMWr, state, illegal, mem_err, retired
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXEC/MEM/WB per
// instruction, waits on a variable-latency data memory, halts on illegal
// instructions or memory timeout, and counts retired instructions.
module mc_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  // Counter only needs to reach ACK_TIMEOUT-1: timeout fires on that cycle.
  localparam int unsigned WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  logic is_add, is_sub, is_jr, is_ori, is_lw, is_sw, is_beq, is_lui, is_jal, legal;

  logic       irwr, pcwr, rfwe, dm_req, dmwr;
  logic [1:0] npcop, a3_sel, wd_sel;
  logic [2:0] alu_op;
  logic       ext_op, alub_sel;

  // Instruction decode from the IR fields
  always_comb begin
    is_add = (bus.opcode == OP_RTYPE) && (bus.funct == FN_ADD);
    is_sub = (bus.opcode == OP_RTYPE) && (bus.funct == FN_SUB);
    is_jr  = (bus.opcode == OP_RTYPE) && (bus.funct == FN_JR);
    is_ori = (bus.opcode == OP_ORI);
    is_lw  = (bus.opcode == OP_LW);
    is_sw  = (bus.opcode == OP_SW);
    is_beq = (bus.opcode == OP_BEQ);
    is_lui = (bus.opcode == OP_LUI);
    is_jal = (bus.opcode == OP_JAL);
    legal  = is_add | is_sub | is_jr | is_ori | is_lw | is_sw | is_beq | is_lui | is_jal;
  end

  // Datapath selects: pure function of the decoded instruction outside FETCH
  always_comb begin
    alu_op   = ALU_ADD;
    a3_sel   = 2'b00;
    wd_sel   = 2'b00;
    ext_op   = 1'b0;
    alub_sel = 1'b0;
    if (state_q != FETCH) begin
      if (is_sub || is_beq) begin
        alu_op = ALU_SUB;
      end else if (is_ori) begin
        alu_op = ALU_OR;
      end else if (is_lui) begin
        alu_op = ALU_LUI;
      end
      ext_op   = is_lw | is_sw;
      alub_sel = is_ori | is_lui | is_lw | is_sw;
      if (is_add || is_sub) begin
        a3_sel = 2'b01;
      end else if (is_jal) begin
        a3_sel = 2'b10;
      end
      if (is_lw) begin
        wd_sel = 2'b01;
      end else if (is_jal) begin
        wd_sel = 2'b10;
      end
    end
  end

  // Next-state, strobes and status updates
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    illegal_d = illegal_q;
    mem_err_d = mem_err_q;
    irwr      = 1'b0;
    pcwr      = 1'b0;
    rfwe      = 1'b0;
    dm_req    = 1'b0;
    dmwr      = 1'b0;
    npcop     = 2'b00;
    case (state_q)
      FETCH: begin
        irwr    = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = HALT;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_beq) begin
          pcwr    = 1'b1;
          npcop   = bus.Zero ? 2'b01 : 2'b00;
          state_d = FETCH;
        end else if (is_jr) begin
          pcwr    = 1'b1;
          npcop   = 2'b11;
          state_d = FETCH;
        end else if (is_jal) begin
          rfwe    = 1'b1;
          pcwr    = 1'b1;
          npcop   = 2'b10;
          state_d = FETCH;
        end else if (is_lw || is_sw) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dm_req = 1'b1;
        dmwr   = is_sw;
        if (bus.dm_ack) begin
          if (is_sw) begin
            pcwr    = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if ((ACK_TIMEOUT != 0) && (wait_q == WAIT_LAST)) begin
          mem_err_d = 1'b1;
          state_d   = HALT;
        end else if (ACK_TIMEOUT != 0) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      WB: begin
        rfwe    = 1'b1;
        pcwr    = 1'b1;
        state_d = FETCH;
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
    // No strobe may escape while reset is held
    if (!reset) begin
      irwr   = 1'b0;
      pcwr   = 1'b0;
      rfwe   = 1'b0;
      dm_req = 1'b0;
      dmwr   = 1'b0;
    end
    retired_d = pcwr ? retired_q + CNT_W'(1) : retired_q;
  end

  // State and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      mem_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      mem_err_q <= mem_err_d;
      retired_q <= retired_d;
    end
  end

  assign bus.IRWr    = irwr;
  assign bus.PCWr    = pcwr;
  assign bus.NPCOp   = npcop;
  assign bus.ALUOp   = alu_op;
  assign bus.A3WRSel = a3_sel;
  assign bus.WDSel   = wd_sel;
  assign bus.EXTOp   = ext_op;
  assign bus.ALUBSel = alub_sel;
  assign bus.RFWE    = rfwe;
  assign bus.dm_req  = dm_req;
  assign bus.DMWr    = dmwr;
  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.mem_err = mem_err_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: random instruction streams against a per-instruction
// cycle-script model; expected cycles are queued, a monitor checks them.
module tb_mc_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 8;

  localparam int K_ILL = 0, K_ADD = 1, K_SUB = 2, K_JR = 3, K_ORI = 4;
  localparam int K_LW = 5, K_SW = 6, K_BEQ = 7, K_LUI = 8, K_JAL = 9;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_ctrl_if #(.CNT_W(CW)) bus ();

  mc_ctrl #(.ACK_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic          irwr;
    logic          pcwr;
    logic [1:0]    npcop;
    logic [2:0]    aluop;
    logic [1:0]    a3;
    logic [1:0]    wdsel;
    logic          extop;
    logic          alubsel;
    logic          rfwe;
    logic          dmreq;
    logic          dmwr;
    logic [2:0]    state;
    logic          illegal;
    logic          memerr;
    logic [CW-1:0] retired;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  // Architectural model state
  int unsigned m_ret;
  bit m_ill, m_merr, m_halt;

  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100000) return K_ADD;
        if (fn == 6'b100010) return K_SUB;
        if (fn == 6'b001000) return K_JR;
        return K_ILL;
      end
      6'b001101: return K_ORI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001111: return K_LUI;
      6'b000011: return K_JAL;
      default:   return K_ILL;
    endcase
  endfunction

  // Expected outputs for a cycle in state st with no strobes yet
  function automatic obs_t base(input int st, input logic [5:0] op, input logic [5:0] fn);
    obs_t o;
    int k;
    o = '0;
    o.state   = 3'(st);
    o.illegal = m_ill;
    o.memerr  = m_merr;
    o.retired = CW'(m_ret);
    if (st != 0) begin
      k = classify(op, fn);
      case (k)
        K_ADD: o.a3 = 2'b01;
        K_SUB: begin o.aluop = 3'b001; o.a3 = 2'b01; end
        K_ORI: begin o.aluop = 3'b010; o.alubsel = 1'b1; end
        K_LUI: begin o.aluop = 3'b011; o.alubsel = 1'b1; end
        K_LW:  begin o.extop = 1'b1; o.alubsel = 1'b1; o.wdsel = 2'b01; end
        K_SW:  begin o.extop = 1'b1; o.alubsel = 1'b1; end
        K_BEQ: o.aluop = 3'b001;
        K_JAL: begin o.a3 = 2'b10; o.wdsel = 2'b10; end
        default: ;
      endcase
    end
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic cyc(input obs_t e, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic ack, input logic rst);
    @(posedge clk);
    #1;
    reset      = rst;
    bus.opcode = op;
    bus.funct  = fn;
    bus.Zero   = z;
    bus.dm_ack = ack;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    obs_t e;
    m_ret = 0; m_ill = 1'b0; m_merr = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = '0;
      cyc(e, r6(), r6(), rbit(), rbit(), 1'b0);
    end
  endtask

  task automatic halt_cycles(input int n);
    obs_t e;
    logic [5:0] op, fn;
    m_halt = 1'b1;
    for (int i = 0; i < n; i++) begin
      op = r6(); fn = r6();
      e = base(5, op, fn);
      cyc(e, op, fn, rbit(), rbit(), 1'b1);
    end
  endtask

  // d = MEM cycle index on which dm_ack arrives; d >= TO never acks in time
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic zexec, input int d);
    obs_t e;
    int k;
    k = classify(op, fn);
    e = base(0, op, fn); e.irwr = 1'b1;
    cyc(e, r6(), r6(), rbit(), rbit(), 1'b1);
    e = base(1, op, fn);
    cyc(e, op, fn, rbit(), rbit(), 1'b1);
    if (k == K_ILL) begin
      m_ill = 1'b1;
      halt_cycles(3);
      return;
    end
    e = base(2, op, fn);
    if (k == K_BEQ || k == K_JR || k == K_JAL) begin
      e.pcwr  = 1'b1;
      e.npcop = (k == K_JR) ? 2'b11 : (k == K_JAL) ? 2'b10 : (zexec ? 2'b01 : 2'b00);
      e.rfwe  = (k == K_JAL);
      cyc(e, op, fn, zexec, rbit(), 1'b1);
      m_ret++;
      return;
    end
    cyc(e, op, fn, rbit(), rbit(), 1'b1);
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < TO; i++) begin
        e = base(3, op, fn); e.dmreq = 1'b1; e.dmwr = (k == K_SW);
        if (i == d) begin
          e.pcwr = (k == K_SW);
          cyc(e, op, fn, rbit(), 1'b1, 1'b1);
          if (k == K_SW) begin
            m_ret++;
            return;
          end
          break;
        end
        cyc(e, op, fn, rbit(), 1'b0, 1'b1);
        if (i == TO - 1) begin
          m_merr = 1'b1;
          halt_cycles(3);
          return;
        end
      end
    end
    e = base(4, op, fn); e.rfwe = 1'b1; e.pcwr = 1'b1;
    cyc(e, op, fn, rbit(), rbit(), 1'b1);
    m_ret++;
  endtask

  // ALU-class instruction abandoned by reset during its WB cycle
  task automatic abort_in_wb(input logic [5:0] op, input logic [5:0] fn);
    obs_t e;
    e = base(0, op, fn); e.irwr = 1'b1;
    cyc(e, r6(), r6(), rbit(), rbit(), 1'b1);
    e = base(1, op, fn);
    cyc(e, op, fn, rbit(), rbit(), 1'b1);
    e = base(2, op, fn);
    cyc(e, op, fn, rbit(), rbit(), 1'b1);
    do_reset(2);
  endtask

  task automatic pick_legal(output logic [5:0] op, output logic [5:0] fn);
    fn = r6();
    case ($urandom_range(0, 8))
      0: begin op = 6'b000000; fn = 6'b100000; end
      1: begin op = 6'b000000; fn = 6'b100010; end
      2: begin op = 6'b000000; fn = 6'b001000; end
      3: op = 6'b001101;
      4: op = 6'b100011;
      5: op = 6'b101011;
      6: op = 6'b000100;
      7: op = 6'b001111;
      default: op = 6'b000011;
    endcase
  endtask

  task automatic pick_illegal(output logic [5:0] op, output logic [5:0] fn);
    op = 6'b111111; fn = r6();
    for (int t = 0; t < 64; t++) begin
      op = ($urandom_range(0, 1) == 0) ? 6'b000000 : r6();
      fn = r6();
      if (classify(op, fn) == K_ILL) return;
    end
    op = 6'b111111;
  endtask

  // Monitor: compare every cycle for which an expectation is queued
  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{irwr: bus.IRWr, pcwr: bus.PCWr, npcop: bus.NPCOp, aluop: bus.ALUOp,
            a3: bus.A3WRSel, wdsel: bus.WDSel, extop: bus.EXTOp, alubsel: bus.ALUBSel,
            rfwe: bus.RFWE, dmreq: bus.dm_req, dmwr: bus.DMWr, state: bus.state,
            illegal: bus.illegal, memerr: bus.mem_err, retired: bus.retired};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t exp_state=%0d: got %p required %p", $time, e.state, a, e);
      end
    end
  end

  initial begin
    logic [5:0] op, fn;
    reset = 1'b0;
    bus.opcode = '0; bus.funct = '0; bus.Zero = 1'b0; bus.dm_ack = 1'b0;

    do_reset(3);
    run_instr(6'b001101, 6'b110100, 1'b0, 0);   // ori
    run_instr(6'b000100, r6(), 1'b1, 0);        // beq taken
    run_instr(6'b000100, r6(), 1'b0, 0);        // beq not taken
    run_instr(6'b100011, r6(), 1'b0, 3);        // lw, ack on 4th MEM cycle
    run_instr(6'b000011, r6(), 1'b0, 0);        // jal
    run_instr(6'b000000, 6'b001000, 1'b0, 0);   // jr
    run_instr(6'b000000, 6'b100000, 1'b0, 0);   // add
    run_instr(6'b000000, 6'b100010, 1'b0, 0);   // sub
    run_instr(6'b001111, r6(), 1'b0, 0);        // lui
    run_instr(6'b101011, r6(), 1'b0, 0);        // sw, zero-wait

    // Long legal stream: enough retirements to wrap the 8-bit counter
    for (int i = 0; i < 320; i++) begin
      pick_legal(op, fn);
      run_instr(op, fn, rbit(), $urandom_range(0, TO - 1));
    end

    run_instr(6'b101011, r6(), 1'b0, 99);       // sw timeout
    do_reset(2);
    run_instr(6'b111111, r6(), 1'b0, 0);        // illegal
    do_reset(2);
    abort_in_wb(6'b001101, r6());

    // Mixed stream with illegal ops, timeouts and mid-instruction resets
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        abort_in_wb(6'b000000, 6'b100000);
      end else begin
        if ($urandom_range(0, 9) == 0) pick_illegal(op, fn);
        else pick_legal(op, fn);
        run_instr(op, fn, rbit(), $urandom_range(0, TO + 1));
        if (m_halt) do_reset(2);
      end
    end

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
